tx_fifo_rd_stage: RTL and testbench
===================================

# tx_fifo_rd_stage

Read-side output stage for the TX async FIFO, clocked in the read domain. It issues pop requests to the FIFO controller and captures the synchronous-RAM read data, which arrives one cycle after each accepted pop. It presents that data downstream as a first-word-fall-through valid/ready stream through a 3-entry buffer. `o_pop` depends on registered state only, so there is no combinational path from `i_ready` back into the controller, and full throughput is sustained.

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and of `o_data`.
- `i_clk`  in  1  read-domain clock; the same clock as the controller read side.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `o_pop`  out  1  pop request to the controller's `i_pop`.
- `i_rden`  in  1  pop accepted by the controller (its `o_rden`), meaning `i_pop & ~empty`.
- `i_rdata`  in  DATA_WIDTH  RAM read data; valid in the cycle after `i_rden`.
- `o_valid`  out  1  `o_data` holds a word.
- `i_ready`  in  1  downstream accepts the word.
- `o_data`  out  DATA_WIDTH  head word of the buffer.
- `o_count`  out  2  buffer occupancy, 0..3.
- `o_err`  out  1  sticky protocol error; cleared only by reset.

## Operation
**State**
- `run` flag.
- `inflight` flag: a registered copy of `i_rden`.
- 3-entry data buffer with 2-bit `head` and `tail`. Each wraps 2 -> 0; value 3 is never reached.
- 2-bit `occ`.

**Start-up**
- `run` clears in reset and sets on the first `i_clk` edge after reset release.

**Pop credit**
- `o_pop = run & (occ + inflight <= 2)`.
- Use a 3-bit sum so there is no overflow.
- Worst case the buffer receives one more word while full minus one, so overflow is impossible in a correct system.

**Capture**
- When `inflight = 1`, write `i_rdata` to `buf[tail]` and advance `tail`.

**Drain**
- `fire = o_valid & i_ready`.
- On `fire`, advance `head`.

**Occupancy**
- `occ_next = occ + inflight - fire`.
- Simultaneous capture and fire leaves `occ` unchanged.
- A capture into an empty buffer while `i_ready = 1` does not fire in the same cycle. The word appears on `o_data` the cycle after capture.

**Outputs**
- `o_valid = (occ != 0)`.
- `o_data = buf[head]`.
- `o_count = occ`.
- `o_data` is held stable while `o_valid & ~i_ready`.

**Errors** (each sets `o_err`)
- `i_rden = 1` while `o_pop = 0`. Data from such a pop is still captured only if `occ + inflight < 3`; otherwise it is dropped.
- A capture when `occ = 3` and no fire occurs; the word is dropped.
- `o_err` never clears except by reset.

**Empty upstream**
- `o_pop` stays asserted. `i_rden` stays low, so nothing is captured; no error.

**Reset mid-operation**
- Buffer, pointers, `occ`, `inflight`, `run` and `o_err` clear asynchronously.
- A word in flight is discarded. Its RAM data, arriving in the first post-reset cycle, is ignored because `inflight` is 0.

## Timing
**Reset values**
- `o_pop = 0`, `o_valid = 0`, `o_data = 0` (buffer cleared), `o_count = 0`, `o_err = 0`.

**Latencies**
- Accepted pop (`i_rden` high at edge N) -> `i_rdata` captured at edge N+1 -> `o_valid` high after edge N+1.
- Pop to `o_valid` is 2 cycles from the cycle `o_pop` is presented.

**Throughput**
- Steady state with `i_ready = 1` and a non-empty FIFO gives one word per cycle: `occ = 1`, `inflight = 1`, `o_pop = 1`.

**Back-pressure**
- With `i_ready = 0`, `o_pop` falls once `occ + inflight = 3`.
- It reasserts the cycle after the first fire drops the sum to 2.

**Combinational paths**
- `i_ready` -> none except through registered state.
- `i_rden` -> none; it is registered into `inflight`.

## Test plan
1. **Reset and start:** hold reset, then release, with the FIFO holding 5 words (0x11..0x15) and `i_ready = 1`. Required: `o_pop` low in reset and in the first cycle; `o_valid` first high 3 cycles after release; words 0x11..0x15 delivered on consecutive cycles; `o_count` ends at 0; `o_err = 0`.
2. **Back-pressure fill:** `i_ready = 0` with 10 words available. Required: exactly 3 words buffered; `o_pop` low; `o_count = 3`; `o_data = 0x00` (first word) held stable. Then raise `i_ready`: all 10 words arrive in order with no gaps after the first.
3. **Alternating ready:** `i_ready` toggles every cycle with 16 words available. Required: every word delivered exactly once in order; `o_count` never exceeds 3; no `o_err`.
4. **Empty upstream:** FIFO empty, `i_rden` held at 0 for 20 cycles. Required: `o_pop` stays 1; `o_valid` stays 0. Then a single `i_rden` pulse with data 0xA5: `o_valid` rises 1 cycle later with `o_data = 0xA5`.
5. **Protocol violation:** force `i_rden = 1` while `o_pop = 0` (buffer full, `i_ready = 0`). Required: `o_err` rises the next cycle and stays high; buffered words are unchanged.
6. **Mid-stream reset:** assert `i_rst_n` low with `occ = 2` and `inflight = 1`. Required: all outputs return to reset values immediately; the first post-reset `i_rdata` is not captured.

Source files
------------

// File: rtl/tx_fifo_rd_stage.sv
// tx_fifo_rd_stage: read-side output stage for the TX async FIFO (read clock domain).
// Issues pops to the FIFO controller, captures RAM read data one cycle after each
// accepted pop, and presents it as a first-word-fall-through valid/ready stream
// through a 3-entry buffer.
// Ports:
//   i_clk, i_rst_n    read-domain clock, async active-low reset
//   o_pop             pop request to controller (registered state only)
//   i_rden            pop accepted by controller (i_pop & ~empty)
//   i_rdata           RAM read data, valid the cycle after i_rden
//   o_valid/i_ready   downstream handshake; o_data is the head word
//   o_count           buffer occupancy 0..3
//   o_err             sticky protocol error, cleared only by reset
module tx_fifo_rd_stage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_pop,
  input  logic                  i_rden,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 3;

  logic                  r_inflight;
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic                  r_pop;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;

  logic                  w_fire;
  logic [2:0]            w_sum;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_stray;
  logic                  w_inflight_n;
  logic [1:0]            w_occ_n;
  logic [1:0]            w_head_n;
  logic [1:0]            w_tail_n;
  logic [2:0]            w_sum_n;
  logic [DATA_WIDTH-1:0] w_buf_n [DEPTH];

  // Pointer increment with 2 -> 0 wrap.
  function automatic logic [1:0] f_wrap(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Next-state computation for buffer, pointers, occupancy and outputs.
  always_comb begin
    w_fire       = r_valid & i_ready;
    w_sum        = 3'(r_occ) + 3'(r_inflight);
    w_stray      = i_rden & ~r_pop;
    // A pop the controller accepted without our request is only tracked if room remains.
    w_inflight_n = i_rden & (w_sum < 3'd3);
    // A capture into a full buffer is allowed only when the head leaves this cycle.
    w_capture    = r_inflight & ((r_occ != 2'd3) | w_fire);
    w_drop       = r_inflight & (r_occ == 2'd3) & ~w_fire;
    w_occ_n      = r_occ + 2'(w_capture) - 2'(w_fire);
    w_head_n     = w_fire    ? f_wrap(r_head) : r_head;
    w_tail_n     = w_capture ? f_wrap(r_tail) : r_tail;
    w_sum_n      = 3'(w_occ_n) + 3'(w_inflight_n);
    for (int i = 0; i < DEPTH; i++) begin
      w_buf_n[i] = r_buf[i];
    end
    if (w_capture) begin
      w_buf_n[r_tail] = i_rdata;
    end
  end

  // State and registered outputs; o_pop going high on the first edge after reset is the run flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_occ      <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_pop      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_n;
      r_head     <= w_head_n;
      r_tail     <= w_tail_n;
      r_occ      <= w_occ_n;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= w_buf_n[i];
      end
      r_pop      <= (w_sum_n <= 3'd2);
      r_valid    <= (w_occ_n != 2'd0);
      r_data     <= w_buf_n[w_head_n];
      r_err      <= r_err | w_stray | w_drop;
    end
  end

  assign o_pop   = r_pop;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_occ;
  assign o_err   = r_err;

endmodule

// File: tb/tb_tx_fifo_rd_stage.sv
// Directed bench for tx_fifo_rd_stage with a small FIFO-controller/RAM model.
module tb_tx_fifo_rd_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       o_pop;
  logic       w_rden;
  logic [7:0] i_rdata = 8'h00;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic [1:0] o_count;
  logic       o_err;

  // Upstream model: words in mem[rd_ptr..wr_ptr-1]; force_* overrides i_rden.
  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;
  logic [7:0] force_data = 8'h00;

  // Delivered-word log.
  logic [7:0] col [64];
  int         col_n = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign w_rden = force_en ? force_val : (o_pop && (rd_ptr != wr_ptr));

  always @(posedge clk) begin
    if (w_rden) begin
      i_rdata <= force_en ? force_data : mem[rd_ptr];
      if (!force_en) rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && o_valid && i_ready && col_n < 64) begin
      col[col_n] <= o_data;
      col_n      <= col_n + 1;
    end
  end

  tx_fifo_rd_stage #(.DATA_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_pop   (o_pop),
    .i_rden  (w_rden),
    .i_rdata (i_rdata),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_err   (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr + i] = base + 8'(i);
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic wait_cnt(input string tag, input logic [1:0] c, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge clk);
      if (o_count === c) found = 1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pop"},   32'(o_pop),   32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_count"}, 32'(o_count), 32'd0);
    chk({tag, "_err"},   32'(o_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int bad;

    // 1: reset and start with 5 words queued.
    rst_n   = 1'b0;
    i_ready = 1'b1;
    load(5, 8'h11);
    repeat (3) @(negedge clk);
    chk_reset("t1_rst");
    rst_n = 1'b1;
    chk("t1_pop_first", 32'(o_pop), 32'd0);
    @(negedge clk);
    chk("t1_pop_e1", 32'(o_pop), 32'd1);
    chk("t1_valid_e1", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_e2", 32'(o_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(o_valid), 32'd1);
      chk("t1_data", 32'(o_data), 32'(8'h11 + 8'(k)));
    end
    @(negedge clk);
    chk("t1_valid_end", 32'(o_valid), 32'd0);
    chk("t1_count_end", 32'(o_count), 32'd0);
    chk("t1_err", 32'(o_err), 32'd0);

    // 2: back-pressure fill then release.
    i_ready = 1'b0;
    load(10, 8'h00);
    repeat (8) @(negedge clk);
    chk("t2_count", 32'(o_count), 32'd3);
    chk("t2_pop", 32'(o_pop), 32'd0);
    chk("t2_valid", 32'(o_valid), 32'd1);
    chk("t2_data", 32'(o_data), 32'h00);
    repeat (2) @(negedge clk);
    chk("t2_data_hold", 32'(o_data), 32'h00);
    chk("t2_count_hold", 32'(o_count), 32'd3);
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t2_stream_valid", 32'(o_valid), 32'd1);
      chk("t2_stream_data", 32'(o_data), 32'(k));
      @(negedge clk);
    end
    chk("t2_valid_end", 32'(o_valid), 32'd0);

    // 3: alternating ready with 16 words.
    i_ready = 1'b0;
    base    = col_n;
    load(16, 8'h20);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      i_ready = ~i_ready;
    end
    i_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_num", 32'(col_n - base), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk("t3_word", 32'(col[base + k]), 32'(8'h20 + 8'(k)));
    end
    chk("t3_err", 32'(o_err), 32'd0);
    chk("t3_count", 32'(o_count), 32'd0);

    // 4: empty upstream, then a single accepted pop.
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(o_pop === 1'b1 && o_valid === 1'b0)) bad++;
    end
    chk("t4_idle", 32'(bad), 32'd0);
    force_en   = 1'b1;
    force_val  = 1'b1;
    force_data = 8'hA5;
    @(negedge clk);
    force_en = 1'b0;
    chk("t4_valid_n", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("t4_valid_n1", 32'(o_valid), 32'd1);
    chk("t4_data", 32'(o_data), 32'hA5);
    @(negedge clk);
    chk("t4_valid_drain", 32'(o_valid), 32'd0);
    chk("t4_err", 32'(o_err), 32'd0);

    // 5: unrequested pop accepted while full.
    i_ready = 1'b0;
    load(3, 8'h31);
    wait_cnt("t5_fill", 2'd3, 20);
    repeat (2) @(negedge clk);
    chk("t5_pop", 32'(o_pop), 32'd0);
    chk("t5_err_pre", 32'(o_err), 32'd0);
    force_en   = 1'b1;
    force_val  = 1'b1;
    force_data = 8'hEE;
    @(negedge clk);
    force_en = 1'b0;
    chk("t5_err_rise", 32'(o_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", 32'(o_err), 32'd1);
    chk("t5_count", 32'(o_count), 32'd3);
    chk("t5_data", 32'(o_data), 32'h31);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_word", 32'(o_data), 32'(8'h31 + 8'(k)));
      @(negedge clk);
    end
    chk("t5_valid_end", 32'(o_valid), 32'd0);
    chk("t5_err_end", 32'(o_err), 32'd1);

    // 6: reset with two words buffered and one in flight.
    i_ready = 1'b0;
    load(8, 8'h40);
    wait_cnt("t6_occ2", 2'd2, 20);
    chk("t6_pop_low", 32'(o_pop), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_count", 32'(o_count), 32'd0);
    chk("t6_err", 32'(o_err), 32'd0);
    chk("t6_pop", 32'(o_pop), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
